seq_detect_ctrl: RTL and testbench

//  Run-time programmable serial pattern-detector controller. Loads a pattern and length

---
 rtl/seq_detect_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_seq_detect_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_ctrl.sv
// Programmable serial pattern detector.
// A pattern, its length, the overlap mode and a match target are loaded through a
// valid/ready handshake. The block then scans a qualified serial stream, pulses
// match for every hit, counts hits and can stop by itself after a target count.
module seq_detect_ctrl #(
    parameter int unsigned PAT_W = 8,  // max pattern length in bits (2..16)
    parameter int unsigned CNT_W = 8   // width of match counter and target
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [4:0]       cfg_len,
    input  logic             cfg_overlap,
    input  logic [CNT_W-1:0] cfg_target,
    input  logic             start,
    input  logic             stop,
    input  logic             din,
    input  logic             din_valid,
    output logic             match,
    output logic             done,
    output logic             busy,
    output logic             cfg_err,
    output logic [CNT_W-1:0] match_count
);

    typedef enum logic [1:0] {
        StIdle,
        StLoaded,
        StRun,
        StDone
    } state_e;

    localparam logic [4:0]       LenMin  = 5'd2;
    localparam logic [4:0]       LenMax  = 5'(PAT_W);
    localparam logic [CNT_W-1:0] CntMax  = '1;

    state_e             state_q, state_d;
    logic [PAT_W-1:0]   pat_q, pat_d;
    logic [4:0]         len_q, len_d;
    logic               ovl_q, ovl_d;
    logic [CNT_W-1:0]   tgt_q, tgt_d;
    logic [PAT_W-1:0]   hist_q, hist_d;
    logic [4:0]         bits_q, bits_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               match_q, match_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               cfg_hs;
    logic               len_ok;
    logic [PAT_W-1:0]   len_mask;
    logic [PAT_W-1:0]   hist_shift;
    logic [4:0]         bits_inc;
    logic [CNT_W-1:0]   cnt_inc;
    logic               hit;

    // Handshake qualification; start in LOADED takes priority over a config offer.
    always_comb begin
        cfg_ready = (state_q == StIdle) || ((state_q == StLoaded) && !start);
        cfg_hs    = cfg_valid && cfg_ready;
        len_ok    = (cfg_len >= LenMin) && (cfg_len <= LenMax);
    end

    // Mask selecting the low len_q bits of history and pattern.
    always_comb begin
        len_mask = '0;
        for (int i = 0; i < int'(PAT_W); i++) begin
            len_mask[i] = (5'(i) < len_q);
        end
    end

    // Candidate datapath values for a qualified bit in RUN.
    always_comb begin
        hist_shift = {hist_q[PAT_W-2:0], din};
        bits_inc   = (bits_q == LenMax) ? bits_q : bits_q + 5'd1;
        cnt_inc    = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
        hit        = (bits_inc >= len_q) &&
                     ((hist_shift & len_mask) == (pat_q & len_mask));
    end

    // Next-state and next-output decode for the controller.
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        tgt_d   = tgt_q;
        hist_d  = hist_q;
        bits_d  = bits_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        match_d = 1'b0;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cfg_hs) begin
                    if (len_ok) begin
                        pat_d   = cfg_pattern;
                        len_d   = cfg_len;
                        ovl_d   = cfg_overlap;
                        tgt_d   = cfg_target;
                        err_d   = 1'b0;
                        state_d = StLoaded;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            StLoaded: begin
                if (start) begin
                    hist_d  = '0;
                    bits_d  = '0;
                    cnt_d   = '0;
                    state_d = StRun;
                end else if (cfg_hs) begin
                    if (len_ok) begin
                        pat_d = cfg_pattern;
                        len_d = cfg_len;
                        ovl_d = cfg_overlap;
                        tgt_d = cfg_target;
                        err_d = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            StRun: begin
                // stop suppresses any match on the same cycle
                if (stop) begin
                    state_d = StLoaded;
                end else if (din_valid) begin
                    hist_d = hist_shift;
                    bits_d = bits_inc;
                    if (hit) begin
                        match_d = 1'b1;
                        cnt_d   = cnt_inc;
                        // non-overlap: the next match needs len fresh bits
                        if (!ovl_q) begin
                            bits_d = '0;
                        end
                        if ((tgt_q != '0) && (cnt_inc == tgt_q)) begin
                            done_d  = 1'b1;
                            state_d = StDone;
                        end
                    end
                end
            end

            StDone: begin
                if (stop) begin
                    state_d = StLoaded;
                end else if (start) begin
                    hist_d  = '0;
                    bits_d  = '0;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, configuration, datapath and registered pulse outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            pat_q   <= '0;
            len_q   <= '0;
            ovl_q   <= 1'b0;
            tgt_q   <= '0;
            hist_q  <= '0;
            bits_q  <= '0;
            cnt_q   <= '0;
            match_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            tgt_q   <= tgt_d;
            hist_q  <= hist_d;
            bits_q  <= bits_d;
            cnt_q   <= cnt_d;
            match_q <= match_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign match       = match_q;
    assign done        = done_q;
    assign busy        = (state_q == StRun);
    assign cfg_err     = err_q;
    assign match_count = cnt_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Self-checking bench for seq_detect_ctrl: table-driven bit streams with a scoreboard
// queue of expected outputs, plus hand-written config, collision and reset sequences.
module tb_seq_detect_ctrl;

    localparam int PAT_W = 8;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [PAT_W-1:0] cfg_pattern;
    logic [4:0]       cfg_len;
    logic             cfg_overlap;
    logic [CNT_W-1:0] cfg_target;
    logic             start;
    logic             stop;
    logic             din;
    logic             din_valid;
    logic             match;
    logic             done;
    logic             busy;
    logic             cfg_err;
    logic [CNT_W-1:0] match_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic             dv;
        logic             d;
        logic             stp;
        logic             e_match;
        logic             e_done;
        logic             e_busy;
        logic [CNT_W-1:0] e_cnt;
    } vec_t;

    typedef struct {
        logic             m;
        logic             dn;
        logic             b;
        logic [CNT_W-1:0] c;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    seq_detect_ctrl #(
        .PAT_W(PAT_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_pattern(cfg_pattern),
        .cfg_len    (cfg_len),
        .cfg_overlap(cfg_overlap),
        .cfg_target (cfg_target),
        .start      (start),
        .stop       (stop),
        .din        (din),
        .din_valid  (din_valid),
        .match      (match),
        .done       (done),
        .busy       (busy),
        .cfg_err    (cfg_err),
        .match_count(match_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic dv, input logic d, input logic stp, input logic em,
                       input logic ed, input logic eb, input int ec);
        vec_t v;
        v.dv = dv; v.d = d; v.stp = stp;
        v.e_match = em; v.e_done = ed; v.e_busy = eb; v.e_cnt = CNT_W'(ec);
        tbl.push_back(v);
    endtask

    // Drive every queued vector; expectations go through the scoreboard.
    task automatic run_tbl(input string tag);
        exp_t e;
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            din_valid = tbl[i].dv;
            din       = tbl[i].d;
            stop      = tbl[i].stp;
            e.m = tbl[i].e_match; e.dn = tbl[i].e_done;
            e.b = tbl[i].e_busy;  e.c = tbl[i].e_cnt;
            sb.push_back(e);
            @(posedge clk);
            #1;
            din_valid = 1'b0;
            stop      = 1'b0;
            e = sb.pop_front();
            check($sformatf("%s[%0d] match", tag, i), 32'(match), 32'(e.m));
            check($sformatf("%s[%0d] done", tag, i), 32'(done), 32'(e.dn));
            check($sformatf("%s[%0d] busy", tag, i), 32'(busy), 32'(e.b));
            check($sformatf("%s[%0d] count", tag, i), 32'(match_count), 32'(e.c));
        end
        tbl.delete();
    endtask

    task automatic do_cfg(input logic [7:0] p, input logic [4:0] l, input logic o,
                          input logic [7:0] t);
        @(negedge clk);
        cfg_valid = 1'b1; cfg_pattern = p; cfg_len = l; cfg_overlap = o; cfg_target = t;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        @(negedge clk);
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; cfg_valid = 1'b0; cfg_pattern = '0; cfg_len = '0;
        cfg_overlap = 1'b0; cfg_target = '0; start = 1'b0; stop = 1'b0;
        din = 1'b0; din_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset cfg_ready", 32'(cfg_ready), 32'd1);
        check("reset busy", 32'(busy), 32'd0);
        check("reset match", 32'(match), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset cfg_err", 32'(cfg_err), 32'd0);
        check("reset count", 32'(match_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Overlapping 101
        do_cfg(8'h05, 5'd3, 1'b1, 8'd0);
        check("loaded cfg_ready", 32'(cfg_ready), 32'd1);
        pulse_start();
        check("run busy", 32'(busy), 32'd1);
        check("run cfg_ready", 32'(cfg_ready), 32'd0);
        add(1, 1, 0, 0, 0, 1, 0);
        add(1, 0, 0, 0, 0, 1, 0);
        add(1, 1, 0, 1, 0, 1, 1);
        add(1, 0, 0, 0, 0, 1, 1);
        add(1, 1, 0, 1, 0, 1, 2);
        add(0, 0, 1, 0, 0, 0, 2);
        run_tbl("ovl");
        check("ovl stop cfg_ready", 32'(cfg_ready), 32'd1);

        // Non-overlapping 101
        do_cfg(8'h05, 5'd3, 1'b0, 8'd0);
        pulse_start();
        check("novl start count", 32'(match_count), 32'd0);
        add(1, 1, 0, 0, 0, 1, 0);
        add(1, 0, 0, 0, 0, 1, 0);
        add(1, 1, 0, 1, 0, 1, 1);
        add(1, 0, 0, 0, 0, 1, 1);
        add(1, 1, 0, 0, 0, 1, 1);
        add(0, 0, 1, 0, 0, 0, 1);
        run_tbl("novl");

        // Target of two on 1101
        do_cfg(8'h0D, 5'd4, 1'b0, 8'd2);
        pulse_start();
        add(1, 1, 0, 0, 0, 1, 0);
        add(1, 1, 0, 0, 0, 1, 0);
        add(1, 0, 0, 0, 0, 1, 0);
        add(1, 1, 0, 1, 0, 1, 1);
        add(1, 1, 0, 0, 0, 1, 1);
        add(1, 1, 0, 0, 0, 1, 1);
        add(1, 0, 0, 0, 0, 1, 1);
        add(1, 1, 0, 1, 1, 0, 2);
        add(1, 1, 0, 0, 0, 0, 2);
        add(1, 1, 0, 0, 0, 0, 2);
        add(1, 0, 0, 0, 0, 0, 2);
        add(1, 1, 0, 0, 0, 0, 2);
        run_tbl("tgt");
        pulse_start();
        check("done restart busy", 32'(busy), 32'd1);
        check("done restart count", 32'(match_count), 32'd0);
        pulse_stop();
        check("tgt stop cfg_ready", 32'(cfg_ready), 32'd1);
        check("tgt stop busy", 32'(busy), 32'd0);

        // Gaps in din_valid, then stop on the final bit of a match
        do_cfg(8'h05, 5'd3, 1'b1, 8'd0);
        pulse_start();
        add(1, 1, 0, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 1, 0);
        add(0, 1, 0, 0, 0, 1, 0);
        add(1, 0, 0, 0, 0, 1, 0);
        add(0, 1, 0, 0, 0, 1, 0);
        add(1, 1, 0, 1, 0, 1, 1);
        add(1, 0, 0, 0, 0, 1, 1);
        add(1, 1, 1, 0, 0, 0, 1);
        run_tbl("gap");
        check("gap stop cfg_ready", 32'(cfg_ready), 32'd1);

        // start collides with a config offer in LOADED
        @(negedge clk);
        start = 1'b1; cfg_valid = 1'b1; cfg_len = 5'd1;
        #1;
        check("collide cfg_ready", 32'(cfg_ready), 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0; cfg_valid = 1'b0;
        check("collide busy", 32'(busy), 32'd1);
        check("collide cfg_err", 32'(cfg_err), 32'd0);
        pulse_stop();

        // Illegal length keeps the previous 101 config
        do_cfg(8'hFF, 5'd1, 1'b0, 8'd0);
        check("len1 cfg_err", 32'(cfg_err), 32'd1);
        check("len1 cfg_ready", 32'(cfg_ready), 32'd1);
        pulse_start();
        add(1, 1, 0, 0, 0, 1, 0);
        add(1, 0, 0, 0, 0, 1, 0);
        add(1, 1, 0, 1, 0, 1, 1);
        run_tbl("keep");
        pulse_stop();
        do_cfg(8'h00, 5'd9, 1'b0, 8'd0);
        check("len9 cfg_err", 32'(cfg_err), 32'd1);
        do_cfg(8'hA5, 5'd8, 1'b0, 8'd0);
        check("len8 cfg_err", 32'(cfg_err), 32'd0);
        pulse_start();
        for (int r = 0; r < 2; r++) begin
            add(1, 1, 0, 0, 0, 1, r);
            add(1, 0, 0, 0, 0, 1, r);
            add(1, 1, 0, 0, 0, 1, r);
            add(1, 0, 0, 0, 0, 1, r);
            add(1, 0, 0, 0, 0, 1, r);
            add(1, 1, 0, 0, 0, 1, r);
            add(1, 0, 0, 0, 0, 1, r);
            add(1, 1, 0, 1, 0, 1, r + 1);
        end
        run_tbl("full");

        // Asynchronous reset while a match pulse is showing
        #2;
        rst_n = 1'b0;
        #1;
        check("arst match", 32'(match), 32'd0);
        check("arst busy", 32'(busy), 32'd0);
        check("arst count", 32'(match_count), 32'd0);
        check("arst cfg_ready", 32'(cfg_ready), 32'd1);
        check("arst done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post arst busy", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
